instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Pipeline IF stage that sits directly upstream of instruction_mem.
//  - Owns the PC and drives the memory's word address.
//  - Captures the returned instruction into the IF/ID register.
//  - Applies stall, branch/jump redirect, halt and fault handling.
//  - Memory read is combinational: the address is presented and the instruction is captured in the same cycle.
// PARAMETERS
//  RESET_PC    32'h0000_0000  byte address of first fetch; must be word-aligned
//  IMEM_DEPTH  128            instruction memory depth in words; addresses at or beyond it fault
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  rst             in   1   asynchronous, active-high reset
//  stall           in   1   hazard stall from ID; hold PC and IF/ID
//  redirect_valid  in   1   taken branch/jump from EX
//  redirect_pc     in   32  byte target for redirect
//  halt_req        in   1   stop fetching; only rst leaves HALT
//  imem_addr       out  32  word index to instruction_mem = {2'b00, pc[31:2]}
//  imem_instr      in   32  instruction word returned for imem_addr
//  ifid_valid      out  1   IF/ID holds a real instruction
//  ifid_instr      out  32  captured instruction
//  ifid_pc         out  32  byte PC of ifid_instr
//  ifid_pc_plus4   out  32  ifid_pc + 4, modulo 2^32
//  fetch_fault     out  1   sticky: misaligned or out-of-range PC
//  halted          out  1   1 while in HALT
// BEHAVIOUR
//  Reset values:
//  - pc = RESET_PC; state = BOOT.
//  - ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4 and fetch_fault are all 0; halted = 0.
//  - rst asserted mid-operation clears everything immediately, independent of clk.
//  States:
//  - BOOT: exactly one cycle. No IF/ID capture; pc unchanged. Next state is RUN.
//  - RUN: normal fetch.
//  - HALT: pc and IF/ID contents frozen; ifid_valid = 0; halted = 1. Every input except rst is ignored.
//  Each posedge in RUN is evaluated in this priority order:
//  1. halt_req = 1 -> go to HALT; ifid_valid <= 0; pc holds.
//  2. PC fault, i.e. pc[1:0] != 0 or pc[31:2] >= IMEM_DEPTH:
//     - fetch_fault <= 1; go to HALT; ifid_valid <= 0.
//  3. redirect_valid = 1 -> pc <= redirect_pc; ifid_valid <= 0 (flush). This overrides stall.
//     - A misaligned target is loaded as-is and faults on the following cycle under rule 2.
//  4. stall = 1 -> pc and all IF/ID fields hold, including ifid_valid.
//  5. Otherwise advance:
//     - ifid_instr <= imem_instr; ifid_pc <= pc; ifid_pc_plus4 <= pc + 4; ifid_valid <= 1.
//     - pc <= pc + 4.
//  Arithmetic and latency:
//  - Adds are 32-bit and wrap modulo 2^32; a wrapped PC then faults under rule 2.
//  - imem_addr is combinational from pc; it is valid in BOOT and HALT as well.
//  - Latency: an instruction at PC p appears on ifid_* one cycle after pc = p with stall = 0.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//  - Adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0]; both reset to 0 and saturate at 32'hFFFF_FFFF.
//  - perf_fetch_cnt increments on every rule-5 advance.
//  - perf_stall_cnt increments on every RUN cycle resolved by rule 4.
//  FETCH_PERF_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package mips32_pkg:
//  - fetch_state_t {BOOT, RUN, HALT}
//  - INSTR_W = 32
//  - NOP_INSTR = 32'h0000_0000
//  - DEFAULT_RESET_PC
//  Sub-module mips32_if_id_reg: a plain register holding valid/instr/pc/pc_plus4.
//  - Inputs: load, flush, hold.
//  - Async reset is active-high.
//  The FSM, PC update and fault check live in the top level.
// TESTING
//  1. rst pulse, imem returns mem[i] = i+1 -> BOOT for 1 cycle, then ifid_pc = 0, 4, 8 with ifid_instr = 1, 2, 3.
//  2. stall = 1 for 3 cycles at pc = 8 -> imem_addr stays 2; ifid_pc stays 4 with ifid_valid = 1; resumes to ifid_pc = 8.
//  3. redirect_valid = 1, redirect_pc = 32'h40, together with stall = 1:
//     - Next cycle ifid_valid = 0 and imem_addr = 16.
//     - The cycle after, ifid_pc = 32'h40.
//  4. redirect_pc = 32'h42 -> one cycle later fetch_fault = 1 and halted = 1; fetch_fault stays 1 until rst.
//  5. Run sequentially to pc = 32'h200 (IMEM_DEPTH 128) -> fetch_fault = 1; last valid ifid_pc = 32'h1FC.
//  6. halt_req together with redirect_valid -> HALT wins and pc is unchanged.
//     - Assert rst mid-HALT -> all outputs return to 0 and pc = RESET_PC asynchronously.

Source files
------------

// File: rtl/mips32_pkg.sv
// mips32_pkg: shared types and constants for the MIPS32 fetch slice.
//   fetch_state_t     BOOT / RUN / HALT states of the fetch FSM
//   INSTR_W           instruction width in bits
//   NOP_INSTR         value an empty IF/ID slot holds
//   DEFAULT_RESET_PC  default byte address of the first fetch
//   pc_faults()       misaligned or out-of-range PC check
package mips32_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A PC is unusable if it is not word-aligned or its word index lies past
    // the end of instruction memory.
    function automatic logic pc_faults(input logic [31:0] pc, input int depth);
        return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/mips32_if_id_reg.sv
// mips32_if_id_reg: IF/ID pipeline register holding valid/instr/pc/pc_plus4.
//   clk, rst            clock and asynchronous active-high reset
//   load                capture the fetch_* inputs and set valid
//   flush               clear valid, keep the other fields (wins over hold/load)
//   hold                freeze every field (wins over load)
//   fetch_instr/pc/pc_plus4   values to capture
//   valid/instr/pc/pc_plus4   registered IF/ID contents
module mips32_if_id_reg
    import mips32_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic               hold,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [31:0]        fetch_pc,
    input  logic [31:0]        fetch_pc_plus4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc       <= 32'h0;
            pc_plus4 <= 32'h0;
        end else if (flush) begin
            valid    <= 1'b0;
        end else if (load && !hold) begin
            valid    <= 1'b1;
            instr    <= fetch_instr;
            pc       <= fetch_pc;
            pc_plus4 <= fetch_pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage owning the PC, driving instruction_mem and the IF/ID register.
// Optional feature macro: FETCH_PERF_EN adds saturating perf_fetch_cnt / perf_stall_cnt.
//   clk, rst          clock and asynchronous active-high reset
//   stall             hold PC and IF/ID
//   redirect_valid    taken branch/jump; loads redirect_pc and flushes IF/ID
//   redirect_pc       byte target of the redirect
//   halt_req          enter HALT; only rst leaves it
//   imem_addr         word index {2'b00, pc[31:2]} to instruction memory
//   imem_instr        instruction returned combinationally for imem_addr
//   ifid_valid/instr/pc/pc_plus4   IF/ID register contents
//   fetch_fault       sticky misaligned / out-of-range PC flag
//   halted            1 while in HALT
//   perf_fetch_cnt    (FETCH_PERF_EN) count of advances
//   perf_stall_cnt    (FETCH_PERF_EN) count of stalled RUN cycles
module instr_fetch_unit
    import mips32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_DEPTH = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [31:0]        ifid_pc,
    output logic [31:0]        ifid_pc_plus4,
    output logic               fetch_fault,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_plus4;
    logic         pc_fault, run;
    logic         do_halt, set_fault, do_redirect, do_stall, do_advance;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = {2'b00, pc[31:2]};
    assign pc_fault  = pc_faults(pc, IMEM_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state == BOOT ? RUN  :
                     do_halt       ? HALT : state;
    end

    // RUN-cycle decode in priority order: halt, fault, redirect, stall, advance.
    always_comb begin
        run         = state == RUN;
        halted      = state == HALT;
        do_halt     = run && (halt_req || pc_fault);
        set_fault   = run && !halt_req && pc_fault;
        do_redirect = run && !do_halt && redirect_valid;
        do_stall    = run && !do_halt && !redirect_valid && stall;
        do_advance  = run && !do_halt && !redirect_valid && !stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
        end else begin
            pc          <= do_redirect ? redirect_pc :
                           do_advance  ? pc_plus4    : pc;
            fetch_fault <= fetch_fault || set_fault;
        end
    end

    mips32_if_id_reg u_if_id (
        .clk            (clk),
        .rst            (rst),
        .load           (do_advance),
        .flush          (do_halt || do_redirect),
        .hold           (do_stall),
        .fetch_instr    (imem_instr),
        .fetch_pc       (pc),
        .fetch_pc_plus4 (pc_plus4),
        .valid          (ifid_valid),
        .instr          (ifid_instr),
        .pc             (ifid_pc),
        .pc_plus4       (ifid_pc_plus4)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (do_advance && perf_fetch_cnt != 32'hFFFF_FFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (do_stall && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        fetch_fault;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Memory model: word i holds i+1.
    assign imem_instr = imem_addr + 32'd1;

    instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(128)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .fetch_fault    (fetch_fault),
        .halted         (halted)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%h exp=0", ifid_valid); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        vectors++; if (ifid_pc !== 32'h0 || ifid_instr !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL reset_ifid got pc=%h instr=%h p4=%h exp 0", ifid_pc, ifid_instr, ifid_pc_plus4); end
        vectors++; if (fetch_fault !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL reset_flags got fault=%b halted=%b exp 0", fetch_fault, halted); end
        step;
        rst = 1'b0;
        step;
        vectors++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL boot_cycle got valid=%b addr=%h exp 0/0", ifid_valid, imem_addr); end
    endtask

    task automatic test_fetch;
        step;
        vectors++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== 32'h1) begin miscompares++; $display("FAIL fetch0 got v=%b pc=%h instr=%h exp 1/0/1", ifid_valid, ifid_pc, ifid_instr); end
        vectors++; if (ifid_pc_plus4 !== 32'h4 || imem_addr !== 32'h1) begin miscompares++; $display("FAIL fetch0_p4 got p4=%h addr=%h exp 4/1", ifid_pc_plus4, imem_addr); end
        step;
        vectors++; if (ifid_pc !== 32'h4 || ifid_instr !== 32'h2 || imem_addr !== 32'h2) begin miscompares++; $display("FAIL fetch1 got pc=%h instr=%h addr=%h exp 4/2/2", ifid_pc, ifid_instr, imem_addr); end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            vectors++; if (imem_addr !== 32'h2 || ifid_pc !== 32'h4 || ifid_valid !== 1'b1) begin miscompares++; $display("FAIL stall%0d got addr=%h pc=%h v=%b exp 2/4/1", i, imem_addr, ifid_pc, ifid_valid); end
        end
        stall = 1'b0;
        step;
        vectors++; if (ifid_pc !== 32'h8 || ifid_instr !== 32'h3 || imem_addr !== 32'h3) begin miscompares++; $display("FAIL stall_resume got pc=%h instr=%h addr=%h exp 8/3/3", ifid_pc, ifid_instr, imem_addr); end
    endtask

    task automatic test_redirect;
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step;
        stall = 1'b0;
        redirect_valid = 1'b0;
        vectors++; if (ifid_valid !== 1'b0 || imem_addr !== 32'd16) begin miscompares++; $display("FAIL redirect_flush got v=%b addr=%h exp 0/10", ifid_valid, imem_addr); end
        step;
        vectors++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40 || ifid_instr !== 32'd17 || ifid_pc_plus4 !== 32'h44) begin miscompares++; $display("FAIL redirect_target got v=%b pc=%h instr=%h p4=%h exp 1/40/11/44", ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus4); end
    endtask

    task automatic test_misaligned;
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        step;
        redirect_valid = 1'b0;
        vectors++; if (fetch_fault !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL misalign_load got fault=%b v=%b addr=%h exp 0/0/10", fetch_fault, ifid_valid, imem_addr); end
        step;
        vectors++; if (fetch_fault !== 1'b1 || halted !== 1'b1 || ifid_valid !== 1'b0) begin miscompares++; $display("FAIL misalign_fault got fault=%b halted=%b v=%b exp 1/1/0", fetch_fault, halted, ifid_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step;
        step;
        redirect_valid = 1'b0;
        vectors++; if (fetch_fault !== 1'b1 || halted !== 1'b1 || imem_addr !== 32'h10 || ifid_pc !== 32'h40) begin miscompares++; $display("FAIL misalign_sticky got fault=%b halted=%b addr=%h pc=%h exp 1/1/10/40", fetch_fault, halted, imem_addr, ifid_pc); end
        do_reset;
        vectors++; if (fetch_fault !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL misalign_clear got fault=%b halted=%b addr=%h exp 0/0/0", fetch_fault, halted, imem_addr); end
    endtask

    task automatic test_range;
        logic [31:0] last_pc;
        int advances;
        last_pc = 32'hFFFF_FFFF;
        advances = 0;
        do_reset;
        step;
        for (int i = 0; i < 200 && !fetch_fault; i++) begin
            step;
            if (ifid_valid) begin
                last_pc = ifid_pc;
                advances++;
            end
        end
        vectors++; if (fetch_fault !== 1'b1 || halted !== 1'b1) begin miscompares++; $display("FAIL range_fault got fault=%b halted=%b exp 1/1", fetch_fault, halted); end
        vectors++; if (last_pc !== 32'h1FC || advances != 128) begin miscompares++; $display("FAIL range_last got pc=%h n=%0d exp 1fc/128", last_pc, advances); end
        vectors++; if (ifid_valid !== 1'b0 || imem_addr !== 32'd128 || ifid_instr !== 32'h80 || ifid_pc_plus4 !== 32'h200) begin miscompares++; $display("FAIL range_state got v=%b addr=%h instr=%h p4=%h exp 0/80/80/200", ifid_valid, imem_addr, ifid_instr, ifid_pc_plus4); end
    endtask

    task automatic test_halt;
        do_reset;
        step;
        step;
        step;
        halt_req = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step;
        halt_req = 1'b0;
        vectors++; if (halted !== 1'b1 || imem_addr !== 32'h2 || ifid_valid !== 1'b0 || fetch_fault !== 1'b0) begin miscompares++; $display("FAIL halt_wins got halted=%b addr=%h v=%b fault=%b exp 1/2/0/0", halted, imem_addr, ifid_valid, fetch_fault); end
        step;
        step;
        redirect_valid = 1'b0;
        vectors++; if (halted !== 1'b1 || imem_addr !== 32'h2 || ifid_pc !== 32'h4 || ifid_valid !== 1'b0) begin miscompares++; $display("FAIL halt_frozen got halted=%b addr=%h pc=%h v=%b exp 1/2/4/0", halted, imem_addr, ifid_pc, ifid_valid); end
        #3 rst = 1'b1;
        #1;
        vectors++; if (halted !== 1'b0 || imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== 32'h0 || ifid_pc_plus4 !== 32'h0 || fetch_fault !== 1'b0) begin miscompares++; $display("FAIL async_reset got halted=%b addr=%h v=%b pc=%h instr=%h p4=%h fault=%b exp all 0", halted, imem_addr, ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus4, fetch_fault); end
        step;
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_stall;
        test_redirect;
        test_misaligned;
        test_range;
        test_halt;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
